mux_pry_pipe: RTL and testbench

//  Pipelined priority multiplexer with valid/ready streaming on both sides.
//  - Each input transaction carries a priority vector and a data array.
//  - Selects one array element, by fixed priority or round-robin.
//  - Emits the selected element as an output transaction.
//  - Sits between request-collection logic and a shared consumer; successor of the purely combinational priority mux.

---
 rtl/mux_pry_pipe.sv | 166 ++++++++++++++++
 tb/tb_mux_pry_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pry_pipe.sv
// Pipelined priority mux: picks one element of i_ary by fixed priority (MODE=0) or round-robin (MODE=1).
// PIPE=0/1/2 register slices set the latency; defining MUX_PRY_PIPE_IDX_EN adds the o_idx output.
module mux_pry_pipe #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32,
  parameter int  MODE  = 0,
  parameter int  PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_pry,
  input  DAT_T             i_ary [WIDTH],
  output logic             o_vld,
  input  logic             o_rdy,
  output logic             o_hit,
  output DAT_T             o_dat
`ifdef MUX_PRY_PIPE_IDX_EN
  ,
  output logic [$clog2(WIDTH)-1:0] o_idx
`endif
);

  localparam int IW = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "mux_pry_pipe: WIDTH must be >= 2");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $fatal(1, "mux_pry_pipe: MODE must be 0 or 1");
  end
  if (PIPE < 0 || PIPE > 2) begin : g_bad_pipe
    $fatal(1, "mux_pry_pipe: PIPE must be 0, 1 or 2");
  end

  logic             s_vld;
  logic             s_rdy;
  logic [WIDTH-1:0] s_pry;
  DAT_T             s_ary [WIDTH];

  if (PIPE == 2) begin : g_in
    logic             vld_q;
    logic [WIDTH-1:0] pry_q;
    DAT_T             ary_q [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        pry_q <= '0;
        ary_q <= '{default: '0};
      end else if (i_rdy) begin
        vld_q <= i_vld;
        if (i_vld) begin
          pry_q <= i_pry;
          ary_q <= i_ary;
        end
      end
    end

    assign i_rdy = !vld_q || s_rdy;
    assign s_vld = vld_q;
    assign s_pry = pry_q;
    assign s_ary = ary_q;
  end else begin : g_in_bypass
    assign i_rdy = s_rdy;
    assign s_vld = i_vld;
    assign s_pry = i_pry;
    assign s_ary = i_ary;
  end

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] up_idx;
  logic          up_hit;
  logic          sel_hit;
  logic [IW-1:0] sel_idx;
  DAT_T          sel_dat;

  // Round-robin: lowest request at or above ptr, else wrap to the lowest request overall.
  always_comb begin
    lo_idx = '0;
    up_idx = '0;
    up_hit = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (s_pry[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_q) begin
          up_idx = IW'(i);
          up_hit = 1'b1;
        end
      end
    end

    sel_idx = '0;
    if (MODE == 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s_pry[i]) sel_idx = IW'(i);
      end
    end else begin
      sel_idx = up_hit ? up_idx : lo_idx;
    end

    sel_hit = |s_pry;
    sel_dat = sel_hit ? s_ary[sel_idx] : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && s_vld && s_rdy && sel_hit) begin
      ptr_d = (sel_idx == IW'(WIDTH - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  if (PIPE >= 1) begin : g_out
    logic vld_q;
    logic hit_q;
    DAT_T dat_q;
`ifdef MUX_PRY_PIPE_IDX_EN
    logic [IW-1:0] idx_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        hit_q <= 1'b0;
        dat_q <= '0;
`ifdef MUX_PRY_PIPE_IDX_EN
        idx_q <= '0;
`endif
      end else if (s_rdy) begin
        vld_q <= s_vld;
        if (s_vld) begin
          hit_q <= sel_hit;
          dat_q <= sel_dat;
`ifdef MUX_PRY_PIPE_IDX_EN
          idx_q <= sel_idx;
`endif
        end
      end
    end

    assign s_rdy = !vld_q || o_rdy;
    assign o_vld = vld_q;
    assign o_hit = hit_q;
    assign o_dat = dat_q;
`ifdef MUX_PRY_PIPE_IDX_EN
    assign o_idx = idx_q;
`endif
  end else begin : g_out_bypass
    assign s_rdy = o_rdy;
    assign o_vld = s_vld;
    assign o_hit = sel_hit;
    assign o_dat = sel_dat;
`ifdef MUX_PRY_PIPE_IDX_EN
    assign o_idx = sel_idx;
`endif
  end

endmodule

// File: tb/tb_mux_pry_pipe.sv
// Scoreboard bench for mux_pry_pipe over four configurations (mode, width, pipe depth).
module tb_mux_pry_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done [4];

  typedef struct {
    logic       hit;
    logic [7:0] dat;
    int         idx;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_cfg
    localparam int W  = (k >= 2) ? 5 : 8;
    localparam int MD = (k == 0 || k == 3) ? 0 : 1;
    localparam int PP = (k == 1) ? 2 : ((k == 3) ? 0 : 1);
    localparam int NB = (k == 2) ? 10000 : 1500;

    logic         rst_n;
    logic         i_vld;
    logic         i_rdy;
    logic [W-1:0] i_pry;
    logic [7:0]   i_ary [W];
    logic         o_vld;
    logic         o_rdy;
    logic         o_hit;
    logic [7:0]   o_dat;
`ifdef MUX_PRY_PIPE_IDX_EN
    logic [$clog2(W)-1:0] o_idx;
`endif

    exp_t       q[$];
    int         mptr = 0;
    int         rdy_mode = 0;
    logic [7:0] base [W];

    mux_pry_pipe #(.DAT_T(logic [7:0]), .WIDTH(W), .MODE(MD), .PIPE(PP)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_pry (i_pry),
      .i_ary (i_ary),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_hit (o_hit),
      .o_dat (o_dat)
`ifdef MUX_PRY_PIPE_IDX_EN
      ,
      .o_idx (o_idx)
`endif
    );

    // Downstream ready: 0 always, 1 random (75% ready), 2 stalled.
    initial begin
      o_rdy = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          0:       o_rdy = 1'b1;
          1:       o_rdy = ($urandom_range(3) != 0);
          default: o_rdy = 1'b0;
        endcase
      end
    end

    // Monitor: pops the scoreboard on every output beat and checks held payload under stall.
    initial begin
      exp_t       e;
      bit         held;
      logic [8:0] held_pl;
      held = 1'b0;
      held_pl = '0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          held = 1'b0;
        end else begin
          if (held) chk($sformatf("c%0d stall_hold", k), {o_vld, o_hit, o_dat}, {1'b1, held_pl});
          held = o_vld && !o_rdy;
          held_pl = {o_hit, o_dat};
          if (o_vld && o_rdy) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL c%0d extra_beat: got dat=%0h, expected no beat", k, o_dat);
            end else begin
              e = q.pop_front();
              chk($sformatf("c%0d hit", k), o_hit, e.hit);
              chk($sformatf("c%0d dat", k), o_dat, e.dat);
`ifdef MUX_PRY_PIPE_IDX_EN
              chk($sformatf("c%0d idx", k), o_idx, e.idx);
              chk($sformatf("c%0d idx_range", k), o_idx <= W - 1, 1);
`endif
            end
          end
        end
      end
    end

    function automatic exp_t model(input logic [W-1:0] p, input logic [7:0] a [W]);
      exp_t e;
      e.hit = 1'b0;
      e.dat = '0;
      e.idx = 0;
      for (int n = 0; n < W; n++) begin
        int i;
        i = (MD == 0) ? (W - 1 - n) : ((mptr + n) % W);
        if (!e.hit && p[i]) begin
          e.hit = 1'b1;
          e.idx = i;
          e.dat = a[i];
        end
      end
      if (MD == 1 && e.hit) mptr = (e.idx + 1) % W;
      return e;
    endfunction

    task automatic send(input logic [W-1:0] p, input logic [7:0] a [W], input exp_t e, output int waited);
      waited = 0;
      i_vld = 1'b1;
      i_pry = p;
      i_ary = a;
      forever begin
        @(negedge clk);
        if (i_rdy) begin
          q.push_back(e);
          break;
        end
        waited++;
        if (waited > 300) begin
          checks++;
          errors++;
          $display("FAIL c%0d send_timeout: got no i_rdy in %0d cycles, expected acceptance", k, waited);
          break;
        end
      end
      @(posedge clk);
      #1;
      i_vld = 1'b0;
    endtask

    // Directed beat with hand-computed result; must be accepted without waiting.
    task automatic dv(input logic [7:0] p, input logic h, input logic [7:0] d, input int ix);
      exp_t e;
      int   w;
      e.hit = h;
      e.dat = d;
      e.idx = ix;
      send(p[W-1:0], base, e, w);
      chk($sformatf("c%0d tput", k), w, 0);
    endtask

    task automatic stall_burst();
      exp_t e;
      int   w;
      for (int j = 0; j < 4; j++) begin
        e.hit = 1'b1;
        e.dat = 8'(j * 16);
        e.idx = j;
        send(W'(1 << j), base, e, w);
      end
    endtask

    task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 500) begin
        @(posedge clk);
        t++;
      end
      chk($sformatf("c%0d drain", k), q.size(), 0);
      @(posedge clk);
      #1;
    endtask

    initial begin
      exp_t         e;
      logic [7:0]   a [W];
      logic [W-1:0] p;
      int           w;

      for (int i = 0; i < W; i++) base[i] = 8'(i * 16);
      rst_n = 1'b0;
      i_vld = 1'b1;
      i_pry = '1;
      i_ary = base;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("c%0d rst_vld", k), o_vld, PP == 0);
      chk($sformatf("c%0d rst_hit", k), o_hit, PP == 0);
      chk($sformatf("c%0d rst_dat", k), o_dat, (PP == 0) ? base[(MD == 0) ? W - 1 : 0] : 8'h00);
      @(posedge clk);
      #1;
      i_vld = 1'b0;
      i_pry = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: a pry==0 beat, leaves the RR pointer at 0.
      i_vld = 1'b1;
      e.hit = 1'b0;
      e.dat = '0;
      e.idx = 0;
      @(negedge clk);
      chk($sformatf("c%0d lat_rdy", k), i_rdy, 1);
      q.push_back(e);
      chk($sformatf("c%0d lat0", k), o_vld, PP == 0);
      @(posedge clk);
      #1;
      i_vld = 1'b0;
      @(negedge clk);
      chk($sformatf("c%0d lat1", k), o_vld, PP == 1);
      @(negedge clk);
      chk($sformatf("c%0d lat2", k), o_vld, PP == 2);
      @(negedge clk);
      chk($sformatf("c%0d lat3", k), o_vld, 0);
      @(posedge clk);
      #1;

      case (k)
        0: begin
          dv(8'b0010_0110, 1'b1, 8'h50, 5);
          dv(8'h00, 1'b0, 8'h00, 0);
          dv(8'h01, 1'b1, 8'h00, 0);
          dv(8'h80, 1'b1, 8'h70, 7);
          dv(8'hFF, 1'b1, 8'h70, 7);
        end
        1: begin
          for (int j = 0; j < 9; j++) dv(8'hFF, 1'b1, 8'((j % 8) * 16), j % 8);
          dv(8'b0000_0101, 1'b1, 8'h20, 2);
          dv(8'b0000_0101, 1'b1, 8'h00, 0);
          dv(8'h00, 1'b0, 8'h00, 0);
          dv(8'hFF, 1'b1, 8'h10, 1);
        end
        2: begin
          for (int j = 0; j < 6; j++) dv(8'h1F, 1'b1, 8'((j % 5) * 16), j % 5);
          dv(8'h00, 1'b0, 8'h00, 0);
          dv(8'h1F, 1'b1, 8'h10, 1);
          dv(8'b1_0100, 1'b1, 8'h20, 2);
          dv(8'b0_0011, 1'b1, 8'h00, 0);
        end
        default: begin
          dv(8'b1_0000, 1'b1, 8'h40, 4);
          dv(8'b0_0110, 1'b1, 8'h20, 2);
          dv(8'h00, 1'b0, 8'h00, 0);
          dv(8'h1F, 1'b1, 8'h40, 4);
        end
      endcase
      drain();

      // Stall: only as many beats as there are slices get in.
      rdy_mode = 2;
      @(posedge clk);
      #2;
      fork
        stall_burst();
      join_none
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk($sformatf("c%0d stall_cnt", k), q.size(), PP);
      chk($sformatf("c%0d stall_rdy", k), i_rdy, 0);
      rdy_mode = 0;
      wait fork;
      drain();

      // Reset with beats in flight: nothing may come out afterwards.
      rdy_mode = 2;
      @(posedge clk);
      #2;
      i_vld = 1'b1;
      i_pry = '1;
      i_ary = base;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      i_vld = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      mptr = 0;
      rst_n = 1'b1;
      rdy_mode = 0;
      repeat (4) begin
        @(negedge clk);
        chk($sformatf("c%0d post_rst_vld", k), o_vld, 0);
      end
      @(posedge clk);
      #1;

      rdy_mode = 1;
      for (int n = 0; n < NB; n++) begin
        for (int i = 0; i < W; i++) a[i] = 8'($urandom);
        p = W'($urandom & $urandom);
        if ($urandom_range(7) == 0) p = '0;
        e = model(p, a);
        send(p, a, e, w);
        if ($urandom_range(3) == 0) begin
          repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      rdy_mode = 0;
      drain();
      done[k] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2] && done[3]) && cyc < 90000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1] && done[2] && done[3])) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got %0d%0d%0d%0d done flags, expected 1111", done[0], done[1], done[2], done[3]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
